// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding.
// Imported by the RTL and by the bench for state checks.
package serial_adder_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ILL  = 2'd3
    } state_t;

endpackage

// File: rtl/serial_adder_full_add.sv
// Purely combinational one-bit full adder; the per-bit datapath of serial_adder.
module serial_adder_full_add (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: captures a/b/cin on an accepted start, adds one bit per
// clock LSB-first through a single full-add cell, then presents {cout,sum}.
//
// Handshake: start is accepted on a rising edge where ready==1 (IDLE or DONE);
// done pulses for one cycle when sum/cout are updated; start during busy is ignored.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output state_t       dbg_state
);

    localparam int CNT_W = $clog2(W + 1);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [W-1:0]     s_sr;
    logic [W-1:0]     s_nxt;
    logic             c_ff;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
    logic             last;
    logic             unused_sr;

    serial_adder_full_add u_full_add (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (c_ff),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign accept    = start & ready;
    assign last      = (state == ST_RUN) && (cnt == CNT_W'(W - 1));
    assign dbg_state = state;
    // The LSB of the sum shifter falls off the end each step; it is never read back.
    assign unused_sr = ^s_sr;

    generate
        if (W == 1) begin : g_narrow
            assign s_nxt = fa_sum;
        end else begin : g_wide
            assign s_nxt = {fa_sum, s_sr[W-1:1]};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ready     = 1'b1;
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c_ff  <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= last;
            if (accept) begin
                a_sr <= a;
                b_sr <= b;
                c_ff <= cin;
                cnt  <= '0;
            end else if (state == ST_RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                s_sr <= s_nxt;
                c_ff <= fa_carry;
                cnt  <= cnt + CNT_W'(1);
                if (last) begin
                    sum  <= s_nxt;
                    cout <= fa_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a W=8 instance and a W=1 instance, checked against
// the arithmetic reference {cout,sum} = a + b + cin.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // W=8 instance
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         ready, busy, done, cout;
    logic [W-1:0] sum;
    state_t       st8;

    serial_adder #(.W(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout),
        .dbg_state(st8)
    );

    // W=1 instance
    logic       s1_start = 1'b0;
    logic [0:0] s1_a = '0;
    logic [0:0] s1_b = '0;
    logic       s1_cin = 1'b0;
    logic       s1_ready, s1_busy, s1_done, s1_cout;
    logic [0:0] s1_sum;
    state_t     st1;

    serial_adder #(.W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
        .ready(s1_ready), .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout),
        .dbg_state(st1)
    );

    // scoreboard
    logic [W:0] exp_q[$];
    logic [1:0] exp1_q[$];
    int cmp_cnt = 0;
    int fail_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
    endfunction

    task automatic check_result(input string tag);
        logic [W:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_done"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_result"}, {cout, sum}, e);
        end
    endtask

    // Launch one op on the W=8 instance; optionally pulse start with a=8'h11
    // after pulse_at busy cycles to show it is ignored.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input string tag, input int pulse_at);
        int   n;
        logic extra;
        @(negedge clk);
        chk({tag, "_ready"}, ready, 1);
        a = av; b = bv; cin = cv; start = 1'b1;
        exp_q.push_back(ref_add(av, bv, cv));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        chk({tag, "_run_state"}, st8, ST_RUN);
        n = 0;
        extra = 1'b0;
        while (busy && n < 100) begin
            if (done) extra = 1'b1;
            if (n == pulse_at) begin
                start = 1'b1; a = 8'h11;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_busy_len"}, n, W);
        chk({tag, "_done_in_run"}, extra, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_state"}, st8, ST_DONE);
        check_result(tag);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_idle_after"}, st8, ST_IDLE);
        chk({tag, "_sum_held"}, {cout, sum}, ref_add(av, bv, cv));
    endtask

    task automatic do_op1(input logic av, input logic bv, input logic cv);
        logic [1:0] e;
        @(negedge clk);
        s1_a = av; s1_b = bv; s1_cin = cv; s1_start = 1'b1;
        exp1_q.push_back(2'(av) + 2'(bv) + 2'(cv));
        @(negedge clk);
        s1_start = 1'b0;
        chk("w1_busy", s1_busy, 1);
        chk("w1_no_early_done", s1_done, 0);
        @(negedge clk);
        chk("w1_done", s1_done, 1);
        e = exp1_q.pop_front();
        chk("w1_result", {s1_cout, s1_sum}, e);
        @(negedge clk);
        chk("w1_done_pulse", s1_done, 0);
    endtask

    initial begin
        int launched, got, last_t;
        logic seen;
        logic [W-1:0] ra, rb;
        logic rc;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", {cout, sum}, 0);
        chk("rst_state", st8, ST_IDLE);
        chk("rst_w1_state", st1, ST_IDLE);
        rst_n = 1'b1;

        // directed ops
        do_op(8'h5A, 8'h3C, 1'b0, "d5a3c", -1);
        do_op(8'hFF, 8'h01, 1'b0, "dff01", -1);
        do_op(8'hFF, 8'hFF, 1'b1, "dffff", -1);

        // start pulsed mid-run is ignored
        do_op(8'h10, 8'h01, 1'b0, "midstart", 3);
        seen = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("midstart_no_extra_done", seen, 0);

        // randomized ops
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(0, 1));
            do_op(ra, rb, rc, "rand", -1);
        end

        // back-to-back with start held high through DONE
        launched = 0; got = 0; last_t = 0;
        for (int k = 0; k < 80 && got < 3; k++) begin
            @(negedge clk);
            if (done) begin
                got++;
                check_result("b2b");
                if (got > 1) chk("b2b_gap", cyc - last_t, W + 1);
                last_t = cyc;
            end
            if (ready && launched < 3) begin
                ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
                a = ra; b = rb; cin = rc; start = 1'b1;
                exp_q.push_back(ref_add(ra, rb, rc));
                launched++;
            end else if (!ready) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                if (launched == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_count", got, 3);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // reset mid-run at bit 4
        @(negedge clk);
        a = 8'hC3; b = 8'h7E; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sum", {cout, sum}, 0);
        chk("midrst_state", st8, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 0);
        chk("midrst_sum_still0", {cout, sum}, 0);
        do_op(8'h01, 8'h01, 1'b0, "post_rst", -1);

        // W=1 instance, all combinations
        for (int i = 0; i < 8; i++) begin
            do_op1(i[2], i[1], i[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
